// File: rtl/pp_column_streamer.sv
`default_nettype none
// ============================================================================
// Module      : pp_column_streamer
// Description : Accepts one BITWIDTH x BITWIDTH operand pair per handshake and
//               streams its partial products column by column (LSB column
//               first), with per-column bit count, Baugh-Wooley plus-one flag
//               and optional truncation of the low columns.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_column_streamer #(
    parameter int BITWIDTH   = 8,
    parameter bit SIGNED     = 1'b0,
    parameter int TRUNC_COLS = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BITWIDTH-1:0]                 in_a,
    input  logic [BITWIDTH-1:0]                 in_b,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [BITWIDTH-1:0]                 out_pp,
    output logic [$clog2(BITWIDTH+1)-1:0]       out_pp_count,
    output logic                                out_plusone,
    output logic [$clog2(2*BITWIDTH)-1:0]       out_col,
    output logic                                out_last
);

    localparam int c_col_w = $clog2(2*BITWIDTH);
    localparam int c_cnt_w = $clog2(BITWIDTH+1);

    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(2*BITWIDTH-1);
    localparam logic [c_col_w-1:0] c_w_col    = c_col_w'(BITWIDTH);
    localparam logic [c_col_w-1:0] c_col_one  = c_col_w'(1);
    localparam logic [BITWIDTH-1:0] c_lsb     = BITWIDTH'(1);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_emit = 1'b1;

    logic [0:0]          r_state;
    logic [BITWIDTH-1:0] r_a;
    logic [BITWIDTH-1:0] r_b;
    logic [c_col_w-1:0]  r_col;

    logic                w_emit;
    logic                w_last;
    logic                w_load;
    logic [BITWIDTH-1:0] w_pp;
    int                  w_cnt;
    int                  w_c;
    int                  w_lo;
    int                  w_hi;
    int                  w_i;
    int                  w_j;
    logic                w_bit;

    assign w_emit = (r_state == c_emit);
    assign w_last = w_emit && (r_col == c_last_col);

    // The last-beat handshake frees the slot in the same cycle, so a new pair
    // can be taken without a bubble.
    assign in_ready = !rst && (!w_emit || (w_last && out_ready));
    assign w_load   = in_valid && in_ready;

    // Two-state controller: capture operands, then walk the column index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_col   <= '0;
        end else if (w_load) begin
            r_state <= c_emit;
            r_a     <= in_a;
            r_b     <= in_b;
            r_col   <= '0;
        end else if (w_emit && out_ready) begin
            if (w_last) begin
                r_state <= c_idle;
                r_col   <= '0;
            end else begin
                r_col   <= r_col + c_col_one;
            end
        end
    end

    // Column decode: terms a[i]&b[c-i] for ascending i, LSB-packed, with the
    // Baugh-Wooley inversion of mixed sign-bit terms and low-column truncation.
    always_comb begin
        w_pp  = '0;
        w_cnt = 0;
        w_bit = 1'b0;
        w_i   = 0;
        w_j   = 0;
        w_c   = int'(r_col);
        w_lo  = (w_c > BITWIDTH-1) ? (w_c - BITWIDTH + 1) : 0;
        w_hi  = (w_c < BITWIDTH-1) ? w_c : (BITWIDTH - 1);
        for (int k = 0; k < BITWIDTH; k++) begin
            w_i = w_lo + k;
            w_j = w_c - w_i;
            if (w_emit && (w_i <= w_hi) && (w_c >= TRUNC_COLS)) begin
                w_bit = (((r_a >> w_i) & c_lsb) != '0) && (((r_b >> w_j) & c_lsb) != '0);
                if (SIGNED && ((w_i == BITWIDTH-1) != (w_j == BITWIDTH-1))) begin
                    w_bit = ~w_bit;
                end
                w_pp  = w_pp | ({{(BITWIDTH-1){1'b0}}, w_bit} << k);
                w_cnt = w_cnt + 1;
            end
        end
    end

    assign out_valid    = w_emit;
    assign out_pp       = w_pp;
    assign out_pp_count = c_cnt_w'(w_cnt);
    assign out_plusone  = w_emit && SIGNED && ((r_col == c_w_col) || (r_col == c_last_col));
    assign out_col      = w_emit ? r_col : '0;
    assign out_last     = w_last;

endmodule
`default_nettype wire

// File: tb/tb_pp_column_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pp_column_streamer
// Description : Drives three streamer variants (unsigned, Baugh-Wooley signed,
//               unsigned with 4 truncated columns) from one stimulus and checks
//               every cycle against a transaction-level column model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_column_streamer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;

    logic       rdy_o  [3];
    logic       v_o    [3];
    logic       plus_o [3];
    logic       last_o [3];
    logic [7:0] pp_o   [3];
    logic [3:0] cnt_o  [3];
    logic [3:0] col_o  [3];

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    // transaction model state
    bit         m_busy = 1'b0;
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    int         m_col = 0;
    int         acc [3] = '{0, 0, 0};
    int         rec_done [3] = '{-1, -1, -1};
    logic [18:0] prev_t [3];
    bit         prev_stall = 1'b0;

    always #5 clk = ~clk;

    pp_column_streamer #(.BITWIDTH(8), .SIGNED(1'b0), .TRUNC_COLS(0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o[0]),
        .in_a(in_a), .in_b(in_b), .out_valid(v_o[0]), .out_ready(out_ready),
        .out_pp(pp_o[0]), .out_pp_count(cnt_o[0]), .out_plusone(plus_o[0]),
        .out_col(col_o[0]), .out_last(last_o[0]));

    pp_column_streamer #(.BITWIDTH(8), .SIGNED(1'b1), .TRUNC_COLS(0)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o[1]),
        .in_a(in_a), .in_b(in_b), .out_valid(v_o[1]), .out_ready(out_ready),
        .out_pp(pp_o[1]), .out_pp_count(cnt_o[1]), .out_plusone(plus_o[1]),
        .out_col(col_o[1]), .out_last(last_o[1]));

    pp_column_streamer #(.BITWIDTH(8), .SIGNED(1'b0), .TRUNC_COLS(4)) u_dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o[2]),
        .in_a(in_a), .in_b(in_b), .out_valid(v_o[2]), .out_ready(out_ready),
        .out_pp(pp_o[2]), .out_pp_count(cnt_o[2]), .out_plusone(plus_o[2]),
        .out_col(col_o[2]), .out_last(last_o[2]));

    // Column c holds every a[i]*b[j] with i+j=c, ascending i.
    function automatic void col_model(input logic [7:0] a, input logic [7:0] b, input int c,
                                      input bit sgn, input int trunc,
                                      output logic [7:0] pp, output int cnt, output bit plus);
        bit bt;
        pp  = '0;
        cnt = 0;
        for (int i = 0; i < W; i++) begin
            int j;
            j = c - i;
            if (j >= 0 && j < W) begin
                bt = (((a >> i) & 8'h01) != 8'h00) && (((b >> j) & 8'h01) != 8'h00);
                if (sgn && ((i == W-1) != (j == W-1))) bt = ~bt;
                if (c >= trunc) begin
                    pp  = pp | (8'(bt) << cnt);
                    cnt = cnt + 1;
                end
            end
        end
        plus = sgn && (c == W || c == 2*W-1);
    endfunction

    // Expected reconstruction, mod 2^16, for variant d.
    function automatic int prod(input logic [7:0] a, input logic [7:0] b, input int d);
        int p;
        logic [7:0] pp;
        int cnt;
        bit pl;
        if (d == 1) p = int'($signed(a)) * int'($signed(b));
        else        p = int'(a) * int'(b);
        if (d == 2) begin
            for (int c = 0; c < 4; c++) begin
                col_model(a, b, c, 1'b0, 0, pp, cnt, pl);
                p = p - ($countones(pp) << c);
            end
        end
        return p & 32'hFFFF;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic logic [18:0] tup(input int d);
        return {v_o[d], pp_o[d], cnt_o[d], plus_o[d], col_o[d], last_o[d]};
    endfunction

    // Per-cycle compare against the model, then advance the model across the
    // coming rising edge using the inputs now applied.
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 3; d++) begin
                logic [7:0] epp;
                int         ecnt;
                bit         epl;
                int         ecol;
                bit         elast;
                bit         erdy;
                if (m_busy) col_model(m_a, m_b, m_col, d == 1, (d == 2) ? 4 : 0, epp, ecnt, epl);
                else begin epp = '0; ecnt = 0; epl = 1'b0; end
                ecol  = m_busy ? m_col : 0;
                elast = m_busy && (m_col == 2*W-1);
                erdy  = !rst && (!m_busy || (elast && out_ready));
                n_vec++;
                if (v_o[d] !== m_busy || pp_o[d] !== epp || int'(cnt_o[d]) != ecnt ||
                    plus_o[d] !== epl || int'(col_o[d]) != ecol || last_o[d] !== elast ||
                    rdy_o[d] !== erdy) begin
                    n_err++;
                    $display("FAIL beat d%0d t=%0t: got v=%0b pp=%h cnt=%0d p=%0b col=%0d last=%0b rdy=%0b, want v=%0b pp=%h cnt=%0d p=%0b col=%0d last=%0b rdy=%0b",
                             d, $time, v_o[d], pp_o[d], cnt_o[d], plus_o[d], col_o[d], last_o[d], rdy_o[d],
                             m_busy, epp, ecnt, epl, ecol, elast, erdy);
                end
                if (prev_stall) begin
                    n_vec++;
                    if (tup(d) !== prev_t[d]) begin
                        n_err++;
                        $display("FAIL stall_hold d%0d: got %h, want %h", d, tup(d), prev_t[d]);
                    end
                end
                if (rst) acc[d] = 0;
                else if (m_busy && out_ready) begin
                    acc[d] = acc[d] + (($countones(pp_o[d]) + int'(plus_o[d])) << col_o[d]);
                    if (elast) begin
                        rec_done[d] = acc[d] & 32'hFFFF;
                        check($sformatf("recon d%0d", d), rec_done[d], prod(m_a, m_b, d));
                        acc[d] = 0;
                    end
                end
                prev_t[d] = tup(d);
            end
            prev_stall = !rst && m_busy && !out_ready;
            if (rst) begin
                m_busy = 1'b0;
                m_col  = 0;
            end else if (!m_busy || (m_col == 2*W-1 && out_ready)) begin
                if (in_valid) begin
                    m_busy = 1'b1; m_a = in_a; m_b = in_b; m_col = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (out_ready) begin
                m_col = m_col + 1;
            end
        end
    end

    task automatic step(input bit r, input bit v, input logic [7:0] a, input logic [7:0] b, input bit rd);
        rst = r; in_valid = v; in_a = a; in_b = b; out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pair(input logic [7:0] a, input logic [7:0] b);
        step(1'b0, 1'b1, a, b, 1'b1);
        repeat (16) step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
    endtask

    initial begin
        logic [7:0] pp;
        int cnt;
        bit pl;

        // pin the column model on hand-computed values
        col_model(8'hFF, 8'hFF, 0, 1'b0, 0, pp, cnt, pl);  check("model c0 pp", pp, 8'h01);  check("model c0 cnt", cnt, 1);
        col_model(8'hFF, 8'hFF, 7, 1'b0, 0, pp, cnt, pl);  check("model c7 pp", pp, 8'hFF);  check("model c7 cnt", cnt, 8);
        col_model(8'hFF, 8'hFF, 14, 1'b0, 0, pp, cnt, pl); check("model c14 pp", pp, 8'h01); check("model c14 cnt", cnt, 1);
        col_model(8'hFF, 8'hFF, 15, 1'b0, 0, pp, cnt, pl); check("model c15 cnt", cnt, 0);
        col_model(8'hFF, 8'h01, 8, 1'b1, 0, pp, cnt, pl);  check("model s c8 plus", int'(pl), 1);
        col_model(8'hFF, 8'h01, 9, 1'b1, 0, pp, cnt, pl);  check("model s c9 plus", int'(pl), 0);
        col_model(8'hFF, 8'hFF, 3, 1'b0, 4, pp, cnt, pl);  check("model t c3 cnt", cnt, 0);
        check("model prod t", prod(8'hFF, 8'hFF, 2), 64976);

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);

        // first cycle after release
        rst = 1'b0; in_valid = 1'b0;
        #3;
        check("rdy after rst", int'(rdy_o[0]), 1);
        check("valid after rst", int'(v_o[0]), 0);
        @(posedge clk);
        #1;

        run_pair(8'hFF, 8'hFF);
        check("rec FFxFF u", rec_done[0], 65025);
        check("rec FFxFF s", rec_done[1], 1);
        check("rec FFxFF t", rec_done[2], 64976);

        run_pair(8'hFF, 8'h01);
        check("rec s -1x1", rec_done[1], 16'hFFFF);
        run_pair(8'h80, 8'h80);
        check("rec s -128x-128", rec_done[1], 16'h4000);

        // backpressure on column 5
        step(1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1);
        repeat (5)  step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
        repeat (3)  step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
        repeat (11) step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
        check("rec backpressure", rec_done[0], 9900);

        // back-to-back: second pair offered during the last beat
        step(1'b0, 1'b1, 8'h09, 8'h09, 1'b1);
        repeat (15) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        rst = 1'b0; in_valid = 1'b1; in_a = 8'd3; in_b = 8'd5; out_ready = 1'b1;
        #3;
        check("b2b rdy on last", int'(rdy_o[0]), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        check("b2b col0 valid", int'(v_o[0]), 1);
        check("b2b col0 idx", int'(col_o[0]), 0);
        repeat (16) step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
        check("rec b2b", rec_done[0], 15);

        // reset while column 9 is on the bus
        step(1'b0, 1'b1, 8'h77, 8'h55, 1'b1);
        repeat (9) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        rst = 1'b0; in_valid = 1'b0;
        #3;
        check("post-rst valid", int'(v_o[0]), 0);
        check("post-rst rdy", int'(rdy_o[0]), 1);
        @(posedge clk);
        #1;
        run_pair(8'd2, 8'd7);
        check("rec after rst", rec_done[0], 14);

        // random traffic with backpressure and occasional reset
        repeat (1500) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (20) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
